// File: rtl/fft_addr_gen.sv
// Address and progress tracker for the in-place radix-2 DIT FFT: butterfly/stage counters, load/write counters, twiddle index and registered SRAM address.
// Build option: define FFT_BIT_REVERSE_EN to bit-reverse stage-0 sample reads so input can be stored in natural order.
module fft_addr_gen #(
    parameter int LOG2N        = 4,
    parameter int ADDR_W       = 9,
    parameter int TWIDDLE_BASE = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              fft_start,
    input  logic [1:0]        addr_mode,
    input  logic              shift_in_ena,
    input  logic              shift_out_ena,
    input  logic              k_ena,
    input  logic              k_clear,
    input  logic              iteration_ena,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [2:0]        samples_loaded_count,
    output logic              samples_loaded_done,
    output logic              samples_written_done,
    output logic              iteration_done,
    output logic              fft_done,
    output logic [LOG2N-1:0]  stage,
    output logic [LOG2N-2:0]  butterfly
);

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_RD   = 2'b01;
    localparam logic [1:0] MODE_TW   = 2'b10;
    localparam logic [1:0] MODE_WR   = 2'b11;

    localparam logic [LOG2N-2:0] BFLY_LAST  = '1;
    localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);

    logic [LOG2N-1:0]  stage_q;
    logic [LOG2N-2:0]  bfly_q;
    logic [1:0]        load_cnt;
    logic [1:0]        wr_cnt;
    logic [LOG2N-2:0]  k_reg;
    logic              iter_done_q;
    logic              fft_done_q;
    logic [ADDR_W-1:0] addr_q;

    logic [LOG2N-1:0]  b_ext;
    logic [LOG2N-1:0]  half;
    logic [LOG2N-1:0]  pos;
    logic [LOG2N-1:0]  grp;
    logic [LOG2N-1:0]  top_idx;
    logic [LOG2N-1:0]  bot_idx;
    logic [LOG2N-1:0]  top_rd;
    logic [LOG2N-1:0]  bot_rd;
    logic [LOG2N-2:0]  k_idx;
    logic [ADDR_W-1:0] addr_next;
    logic              iter_fire;

`ifdef FFT_BIT_REVERSE_EN
    function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction
`endif

    // Butterfly operand and twiddle indices for the current (stage, butterfly)
    always_comb begin
        b_ext   = {1'b0, bfly_q};
        half    = LOG2N'(1) << stage_q;
        pos     = b_ext & (half - 1'b1);
        grp     = b_ext >> stage_q;
        top_idx = (grp << (stage_q + 1'b1)) + pos;
        bot_idx = top_idx + half;
        k_idx   = pos[LOG2N-2:0] << (LOG2N - 1 - stage_q);
`ifdef FFT_BIT_REVERSE_EN
        top_rd  = (stage_q == '0) ? bit_rev(top_idx) : top_idx;
        bot_rd  = (stage_q == '0) ? bit_rev(bot_idx) : bot_idx;
`else
        top_rd  = top_idx;
        bot_rd  = bot_idx;
`endif
    end

    always_comb begin
        addr_next = addr_q;
        case (addr_mode)
            MODE_RD: begin
                if (load_cnt == 2'd0)      addr_next = ADDR_W'(top_rd);
                else if (load_cnt == 2'd1) addr_next = ADDR_W'(bot_rd);
            end
            MODE_TW: addr_next = ADDR_W'(TWIDDLE_BASE) + ADDR_W'(k_reg);
            MODE_WR: begin
                if (wr_cnt == 2'd0)      addr_next = ADDR_W'(top_idx);
                else if (wr_cnt == 2'd1) addr_next = ADDR_W'(bot_idx);
            end
            MODE_IDLE: addr_next = '0;
            default:   addr_next = '0;
        endcase
    end

    // A finished transform ignores further butterfly completions until restarted
    assign iter_fire = iteration_ena && !fft_done_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stage_q     <= '0;
            bfly_q      <= '0;
            load_cnt    <= '0;
            wr_cnt      <= '0;
            k_reg       <= '0;
            iter_done_q <= 1'b0;
            fft_done_q  <= 1'b0;
        end else if (fft_start) begin
            stage_q     <= '0;
            bfly_q      <= '0;
            load_cnt    <= '0;
            wr_cnt      <= '0;
            k_reg       <= '0;
            iter_done_q <= 1'b0;
            fft_done_q  <= 1'b0;
        end else begin
            if (iter_fire)
                load_cnt <= '0;
            else if (shift_in_ena && load_cnt != 2'd3)
                load_cnt <= load_cnt + 2'd1;

            if (iter_fire)
                wr_cnt <= '0;
            else if (shift_out_ena && wr_cnt != 2'd2)
                wr_cnt <= wr_cnt + 2'd1;

            if (k_clear)
                k_reg <= '0;
            else if (k_ena)
                k_reg <= k_idx;

            iter_done_q <= iter_fire && (bfly_q == BFLY_LAST);

            if (iter_fire) begin
                if (bfly_q == BFLY_LAST) begin
                    bfly_q <= '0;
                    if (stage_q == STAGE_LAST) begin
                        stage_q    <= '0;
                        fft_done_q <= 1'b1;
                    end else begin
                        stage_q <= stage_q + 1'b1;
                    end
                end else begin
                    bfly_q <= bfly_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            addr_q <= '0;
        else
            addr_q <= addr_next;
    end

    assign sram_addr            = addr_q;
    assign samples_loaded_count = {1'b0, load_cnt};
    assign samples_loaded_done  = (load_cnt == 2'd3);
    assign samples_written_done = (wr_cnt == 2'd2);
    assign iteration_done       = iter_done_q;
    assign fft_done             = fft_done_q;
    assign stage                = stage_q;
    assign butterfly            = bfly_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen (N=16): expectations are queued per clock cycle and checked on the falling edge.
module tb_fft_addr_gen;

    localparam int LOG2N  = 4;
    localparam int ADDR_W = 9;
    localparam int TWB    = 64;
    localparam int NH     = 8;
    localparam int NITER  = 32;

`ifdef FFT_BIT_REVERSE_EN
    localparam int EXP_B0  = 8;
    localparam int EXP_T1  = 4;
    localparam int EXP_BT1 = 12;
`else
    localparam int EXP_B0  = 1;
    localparam int EXP_T1  = 2;
    localparam int EXP_BT1 = 3;
`endif

    localparam int SIG_ADDR  = 0;
    localparam int SIG_LCNT  = 1;
    localparam int SIG_LDONE = 2;
    localparam int SIG_WDONE = 3;
    localparam int SIG_IDONE = 4;
    localparam int SIG_FDONE = 5;
    localparam int SIG_STAGE = 6;
    localparam int SIG_BFLY  = 7;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              fft_start = 1'b0;
    logic [1:0]        addr_mode = 2'b00;
    logic              shift_in_ena = 1'b0;
    logic              shift_out_ena = 1'b0;
    logic              k_ena = 1'b0;
    logic              k_clear = 1'b0;
    logic              iteration_ena = 1'b0;
    logic [ADDR_W-1:0] sram_addr;
    logic [2:0]        samples_loaded_count;
    logic              samples_loaded_done;
    logic              samples_written_done;
    logic              iteration_done;
    logic              fft_done;
    logic [LOG2N-1:0]  stage;
    logic [LOG2N-2:0]  butterfly;

    always #5 clk = ~clk;

    fft_addr_gen #(.LOG2N(LOG2N), .ADDR_W(ADDR_W), .TWIDDLE_BASE(TWB)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .fft_start            (fft_start),
        .addr_mode            (addr_mode),
        .shift_in_ena         (shift_in_ena),
        .shift_out_ena        (shift_out_ena),
        .k_ena                (k_ena),
        .k_clear              (k_clear),
        .iteration_ena        (iteration_ena),
        .sram_addr            (sram_addr),
        .samples_loaded_count (samples_loaded_count),
        .samples_loaded_done  (samples_loaded_done),
        .samples_written_done (samples_written_done),
        .iteration_done       (iteration_done),
        .fft_done             (fft_done),
        .stage                (stage),
        .butterfly            (butterfly)
    );

    typedef struct {
        int    cyc;
        string tag;
        int    sig;
        int    exp;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   total_iter = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int get_sig(input int id);
        case (id)
            SIG_ADDR:  return int'(sram_addr);
            SIG_LCNT:  return int'(samples_loaded_count);
            SIG_LDONE: return int'(samples_loaded_done);
            SIG_WDONE: return int'(samples_written_done);
            SIG_IDONE: return int'(iteration_done);
            SIG_FDONE: return int'(fft_done);
            SIG_STAGE: return int'(stage);
            SIG_BFLY:  return int'(butterfly);
            default:   return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            check_eq(cur.tag, get_sig(cur.sig), cur.exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input string tag, input int sig, input int e);
        exp_t x;
        x.cyc = cyc;
        x.tag = tag;
        x.sig = sig;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check_all_zero(input string pfx);
        for (int i = 0; i <= SIG_BFLY; i++) begin
            check_eq($sformatf("%s_sig%0d", pfx, i), get_sig(i), 0);
        end
    endtask

    // Expected progress follows from a plain running count of completed butterflies
    task automatic iter_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            iteration_ena = 1'b1;
            addr_mode     = 2'b00;
            tick();
            total_iter++;
            push("iter_stage", SIG_STAGE, (total_iter >= NITER) ? 0 : total_iter / NH);
            push("iter_bfly",  SIG_BFLY,  (total_iter >= NITER) ? 0 : total_iter % NH);
            push("iter_idone", SIG_IDONE, (total_iter % NH == 0 && total_iter <= NITER) ? 1 : 0);
            push("iter_fdone", SIG_FDONE, (total_iter >= NITER) ? 1 : 0);
            push("iter_addr",  SIG_ADDR,  0);
        end
        iteration_ena = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) tick();
        check_all_zero("rst");
        n_rst = 1'b1;
        tick();

        // Stage 0, butterfly 0 sample loads
        fft_start = 1'b1;
        addr_mode = 2'b01;
        tick();
        fft_start = 1'b0;
        total_iter = 0;
        push("ld0_addr", SIG_ADDR, 0);
        push("ld0_cnt", SIG_LCNT, 0);
        shift_in_ena = 1'b1;
        tick();
        push("ld1_addr", SIG_ADDR, 0);
        push("ld1_cnt", SIG_LCNT, 1);
        tick();
        push("ld2_addr", SIG_ADDR, EXP_B0);
        push("ld2_cnt", SIG_LCNT, 2);
        push("ld2_done", SIG_LDONE, 0);
        tick();
        push("ld3_addr", SIG_ADDR, EXP_B0);
        push("ld3_cnt", SIG_LCNT, 3);
        push("ld3_done", SIG_LDONE, 1);
        tick();
        push("ld_sat_cnt", SIG_LCNT, 3);
        push("ld_sat_done", SIG_LDONE, 1);

        iter_pulses(1);
        push("ld_clr_cnt", SIG_LCNT, 0);
        shift_in_ena = 1'b0;
        iter_pulses(20);

        // s=2, b=5
        addr_mode = 2'b01;
        tick();
        push("s2_top", SIG_ADDR, 9);
        shift_in_ena = 1'b1;
        tick();
        push("s2_top_hold", SIG_ADDR, 9);
        shift_in_ena = 1'b0;
        tick();
        push("s2_bot", SIG_ADDR, 13);
        addr_mode = 2'b10;
        k_ena = 1'b1;
        tick();
        push("tw_old", SIG_ADDR, TWB);
        k_ena = 1'b0;
        tick();
        push("tw_k2", SIG_ADDR, TWB + 2);
        k_clear = 1'b1;
        k_ena = 1'b1;
        tick();
        push("tw_pre_clr", SIG_ADDR, TWB + 2);
        k_clear = 1'b0;
        k_ena = 1'b0;
        tick();
        push("tw_clear_wins", SIG_ADDR, TWB);

        iter_pulses(10);

        // s=3, b=7 write-back
        addr_mode = 2'b11;
        tick();
        push("wr_top", SIG_ADDR, 7);
        shift_out_ena = 1'b1;
        tick();
        push("wr1_addr", SIG_ADDR, 7);
        push("wr1_done", SIG_WDONE, 0);
        tick();
        push("wr2_addr", SIG_ADDR, 15);
        push("wr2_done", SIG_WDONE, 1);
        tick();
        push("wr_sat_addr", SIG_ADDR, 15);
        push("wr_sat_done", SIG_WDONE, 1);
        shift_out_ena = 1'b0;
        tick();
        push("wr_hold_addr", SIG_ADDR, 15);

        iter_pulses(1);
        push("wr_clr_done", SIG_WDONE, 0);
        iter_pulses(1);
        tick();
        push("done_hold", SIG_FDONE, 1);
        push("idone_low", SIG_IDONE, 0);

        fft_start = 1'b1;
        tick();
        fft_start = 1'b0;
        total_iter = 0;
        push("start_fdone", SIG_FDONE, 0);
        push("start_stage", SIG_STAGE, 0);

        // s=0, b=1 reads, with or without reversal
        iter_pulses(1);
        addr_mode = 2'b01;
        tick();
        push("rev_top", SIG_ADDR, EXP_T1);
        shift_in_ena = 1'b1;
        tick();
        push("rev_top_hold", SIG_ADDR, EXP_T1);
        shift_in_ena = 1'b0;
        tick();
        push("rev_bot", SIG_ADDR, EXP_BT1);

        // s=1, b=1: twiddle 4, then a start that collides with everything
        iter_pulses(8);
        k_ena = 1'b1;
        tick();
        k_ena = 1'b0;
        addr_mode = 2'b10;
        tick();
        push("tw_k4", SIG_ADDR, TWB + 4);
        shift_in_ena = 1'b1;
        shift_out_ena = 1'b1;
        tick();
        push("pre_cnt", SIG_LCNT, 1);
        push("pre_stage", SIG_STAGE, 1);
        push("pre_bfly", SIG_BFLY, 1);
        fft_start = 1'b1;
        iteration_ena = 1'b1;
        k_ena = 1'b1;
        tick();
        push("col_cnt", SIG_LCNT, 0);
        push("col_wdone", SIG_WDONE, 0);
        push("col_stage", SIG_STAGE, 0);
        push("col_bfly", SIG_BFLY, 0);
        push("col_idone", SIG_IDONE, 0);
        push("col_fdone", SIG_FDONE, 0);
        fft_start = 1'b0;
        iteration_ena = 1'b0;
        k_ena = 1'b0;
        shift_in_ena = 1'b0;
        shift_out_ena = 1'b0;
        total_iter = 0;
        tick();
        push("col_k_clr", SIG_ADDR, TWB);

        // Mid-stage asynchronous reset
        iter_pulses(10);
        addr_mode = 2'b01;
        shift_in_ena = 1'b1;
        tick();
        shift_in_ena = 1'b0;
        tick();
        push("mid_addr", SIG_ADDR, 6);
        push("mid_cnt", SIG_LCNT, 1);
        push("mid_stage", SIG_STAGE, 1);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        addr_mode = 2'b00;
        tick();
        n_rst = 1'b1;
        tick();
        push("post_rst_stage", SIG_STAGE, 0);
        push("post_rst_addr", SIG_ADDR, 0);
        tick();
        tick();
        check_eq("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
